// File: rtl/flash_address_ctrl_if.sv
// Signal bundle between the flash reader, the keyboard command levels and
// the flash word-address generator.
interface flash_address_ctrl_if #(
  parameter int ADDR_W = 23
);
  logic              address_inc;
  logic              address_dec;
  logic              address_rst;
  logic              cmd_forward;
  logic              cmd_backward;
  logic              cmd_pause;
  logic              cmd_play;
  logic              cmd_restart;
  logic [ADDR_W-1:0] flsh_address;
  logic              direction;
  logic              play_enable;
  logic              wrapped;

  modport master (
    output address_inc,
    output address_dec,
    output address_rst,
    output cmd_forward,
    output cmd_backward,
    output cmd_pause,
    output cmd_play,
    output cmd_restart,
    input  flsh_address,
    input  direction,
    input  play_enable,
    input  wrapped
  );

  modport slave (
    input  address_inc,
    input  address_dec,
    input  address_rst,
    input  cmd_forward,
    input  cmd_backward,
    input  cmd_pause,
    input  cmd_play,
    input  cmd_restart,
    output flsh_address,
    output direction,
    output play_enable,
    output wrapped
  );
endinterface

// File: rtl/flash_address_ctrl.sv
// Flash word-address generator for audio playback: direction and run state
// from edge-detected commands, wrapping address counter between song bounds.
module flash_address_ctrl #(
  parameter int                ADDR_W     = 23,
  parameter logic [ADDR_W-1:0] START_ADDR = 23'h000000,
  parameter logic [ADDR_W-1:0] END_ADDR   = 23'h07FFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  flash_address_ctrl_if.slave  bus
);

  typedef enum logic [0:0] {DIR_FWD = 1'b0, DIR_BWD = 1'b1} dir_e;
  typedef enum logic [0:0] {RUN_PLAYING = 1'b0, RUN_PAUSED = 1'b1} run_e;

  localparam int CMD_FWD = 0;
  localparam int CMD_BWD = 1;
  localparam int CMD_PAU = 2;
  localparam int CMD_PLY = 3;
  localparam int CMD_RST = 4;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [4:0]        cmd_s;
  logic [4:0]        cmd_r;
  logic [4:0]        cmd_d_r;
  logic [4:0]        cmd_ev_s;
  dir_e              dir_state_r;
  dir_e              dir_next_s;
  run_e              run_state_r;
  run_e              run_next_s;
  logic              direction_s;
  logic              play_enable_s;
  logic [ADDR_W-1:0] flsh_address_r;
  logic [ADDR_W-1:0] addr_next_s;
  logic [ADDR_W-1:0] addr_clamp_s;
  logic [ADDR_W-1:0] start_s;
  logic              step_up_s;
  logic              step_dn_s;
  logic              wrapped_r;
  logic              wrap_next_s;

  assign cmd_s = {bus.cmd_restart, bus.cmd_play, bus.cmd_pause,
                  bus.cmd_backward, bus.cmd_forward};

  // Command input register plus its previous value for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_r   <= 5'b00000;
      cmd_d_r <= 5'b00000;
    end else begin
      cmd_r   <= cmd_s;
      cmd_d_r <= cmd_r;
    end
  end

  assign cmd_ev_s = cmd_r & ~cmd_d_r;

  // Direction FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_state_r <= DIR_FWD;
    end else begin
      dir_state_r <= dir_next_s;
    end
  end

  // Direction FSM next state; simultaneous forward/backward events cancel
  always_comb begin
    dir_next_s = dir_state_r;
    case (dir_state_r)
      DIR_FWD: begin
        if (cmd_ev_s[CMD_BWD] && !cmd_ev_s[CMD_FWD]) begin
          dir_next_s = DIR_BWD;
        end else begin
          dir_next_s = DIR_FWD;
        end
      end
      DIR_BWD: begin
        if (cmd_ev_s[CMD_FWD] && !cmd_ev_s[CMD_BWD]) begin
          dir_next_s = DIR_FWD;
        end else begin
          dir_next_s = DIR_BWD;
        end
      end
      default: dir_next_s = DIR_FWD;
    endcase
  end

  // Run FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      run_state_r <= RUN_PLAYING;
    end else begin
      run_state_r <= run_next_s;
    end
  end

  // Run FSM next state; pause has priority over play
  always_comb begin
    run_next_s = run_state_r;
    case (run_state_r)
      RUN_PLAYING: begin
        if (cmd_ev_s[CMD_PAU]) begin
          run_next_s = RUN_PAUSED;
        end else begin
          run_next_s = RUN_PLAYING;
        end
      end
      RUN_PAUSED: begin
        if (cmd_ev_s[CMD_PAU]) begin
          run_next_s = RUN_PAUSED;
        end else if (cmd_ev_s[CMD_PLY]) begin
          run_next_s = RUN_PLAYING;
        end else begin
          run_next_s = RUN_PAUSED;
        end
      end
      default: run_next_s = RUN_PLAYING;
    endcase
  end

  // FSM output decode from registered state only
  always_comb begin
    direction_s   = 1'b0;
    play_enable_s = 1'b1;
    case (dir_state_r)
      DIR_FWD: direction_s = 1'b0;
      DIR_BWD: direction_s = 1'b1;
      default: direction_s = 1'b0;
    endcase
    case (run_state_r)
      RUN_PLAYING: play_enable_s = 1'b1;
      RUN_PAUSED:  play_enable_s = 1'b0;
      default:     play_enable_s = 1'b1;
    endcase
  end

  // Next address: reader reload > restart > step; steps ignore run state
  always_comb begin
    start_s      = (dir_state_r == DIR_BWD) ? END_ADDR : START_ADDR;
    addr_clamp_s = (flsh_address_r > END_ADDR) ? END_ADDR : flsh_address_r;
    step_up_s    = (bus.address_inc && !bus.address_dec && (dir_state_r == DIR_FWD)) ||
                   (bus.address_dec && !bus.address_inc && (dir_state_r == DIR_BWD));
    step_dn_s    = (bus.address_inc && !bus.address_dec && (dir_state_r == DIR_BWD)) ||
                   (bus.address_dec && !bus.address_inc && (dir_state_r == DIR_FWD));
    addr_next_s  = flsh_address_r;
    wrap_next_s  = 1'b0;
    if (bus.address_rst) begin
      addr_next_s = start_s;
    end else if (cmd_ev_s[CMD_RST]) begin
      addr_next_s = start_s;
    end else if (step_up_s) begin
      if (addr_clamp_s == END_ADDR) begin
        addr_next_s = START_ADDR;
        wrap_next_s = 1'b1;
      end else begin
        addr_next_s = addr_clamp_s + ADDR_ONE;
      end
    end else if (step_dn_s) begin
      if (addr_clamp_s <= START_ADDR) begin
        addr_next_s = END_ADDR;
        wrap_next_s = 1'b1;
      end else begin
        addr_next_s = addr_clamp_s - ADDR_ONE;
      end
    end else begin
      addr_next_s = flsh_address_r;
    end
  end

  // Address and wrap-pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      flsh_address_r <= START_ADDR;
      wrapped_r      <= 1'b0;
    end else begin
      flsh_address_r <= addr_next_s;
      wrapped_r      <= wrap_next_s;
    end
  end

  assign bus.flsh_address = flsh_address_r;
  assign bus.wrapped      = wrapped_r;
  assign bus.direction    = direction_s;
  assign bus.play_enable  = play_enable_s;

endmodule

// File: tb/tb_flash_address_ctrl.sv
// Directed table-driven bench for flash_address_ctrl with default song bounds.
module tb_flash_address_ctrl;

  localparam logic [8:0] I_RST   = 9'h100;
  localparam logic [8:0] I_ARST  = 9'h080;
  localparam logic [8:0] I_INC   = 9'h040;
  localparam logic [8:0] I_DEC   = 9'h020;
  localparam logic [8:0] I_FWD   = 9'h010;
  localparam logic [8:0] I_BWD   = 9'h008;
  localparam logic [8:0] I_PAU   = 9'h004;
  localparam logic [8:0] I_PLY   = 9'h002;
  localparam logic [8:0] I_RSTRT = 9'h001;
  localparam logic [8:0] I_NONE  = 9'h000;
  localparam logic [22:0] A_END  = 23'h07FFFF;
  localparam logic [22:0] A_EM1  = 23'h07FFFE;

  typedef struct {
    string       name;
    logic [8:0]  in;
    logic [22:0] addr;
    logic        dir;
    logic        pe;
    logic        wr;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  vec_t vecs[$];

  flash_address_ctrl_if #(.ADDR_W(23)) bus ();

  flash_address_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input string n, input logic [8:0] in, input logic [22:0] a,
                     input logic d, input logic p, input logic w);
    vec_t v;
    v.name = n; v.in = in; v.addr = a; v.dir = d; v.pe = p; v.wr = w;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [8:0] in);
    rst              = in[8];
    bus.address_rst  = in[7];
    bus.address_inc  = in[6];
    bus.address_dec  = in[5];
    bus.cmd_forward  = in[4];
    bus.cmd_backward = in[3];
    bus.cmd_pause    = in[2];
    bus.cmd_play     = in[1];
    bus.cmd_restart  = in[0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string n, input logic [22:0] a, input logic d,
                       input logic p, input logic w);
    n_checks++;
    if (bus.flsh_address !== a || bus.direction !== d ||
        bus.play_enable !== p || bus.wrapped !== w) begin
      n_fail++;
      $display("FAIL %s: got addr=%h dir=%b pe=%b wr=%b, expected addr=%h dir=%b pe=%b wr=%b",
               n, bus.flsh_address, bus.direction, bus.play_enable, bus.wrapped,
               a, d, p, w);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    drive(I_NONE);

    // reset and forward steps
    add("reset0",      I_RST,                 23'd0, 1'b0, 1'b1, 1'b0);
    add("reset1",      I_RST,                 23'd0, 1'b0, 1'b1, 1'b0);
    add("fwd_inc1",    I_INC,                 23'd1, 1'b0, 1'b1, 1'b0);
    add("fwd_inc2",    I_INC,                 23'd2, 1'b0, 1'b1, 1'b0);
    add("fwd_inc3",    I_INC,                 23'd3, 1'b0, 1'b1, 1'b0);
    add("fwd_dec",     I_DEC,                 23'd2, 1'b0, 1'b1, 1'b0);
    // backward command held, then backward wrap both ways
    add("bwd_reg",     I_BWD,                 23'd2, 1'b0, 1'b1, 1'b0);
    add("bwd_ev",      I_BWD,                 23'd2, 1'b1, 1'b1, 1'b0);
    add("bwd_hold",    I_BWD,                 23'd2, 1'b1, 1'b1, 1'b0);
    add("bwd_inc1",    I_BWD | I_INC,         23'd1, 1'b1, 1'b1, 1'b0);
    add("bwd_inc0",    I_INC,                 23'd0, 1'b1, 1'b1, 1'b0);
    add("bwd_wrap",    I_INC,                 A_END, 1'b1, 1'b1, 1'b1);
    add("bwd_wr_off",  I_NONE,                A_END, 1'b1, 1'b1, 1'b0);
    add("bwd_dec_wr",  I_DEC,                 23'd0, 1'b1, 1'b1, 1'b1);
    add("bwd_dec1",    I_DEC,                 23'd1, 1'b1, 1'b1, 1'b0);
    add("bwd_dec2",    I_DEC,                 23'd2, 1'b1, 1'b1, 1'b0);
    add("bwd_dec3",    I_DEC,                 23'd3, 1'b1, 1'b1, 1'b0);
    add("bwd_dec4",    I_DEC,                 23'd4, 1'b1, 1'b1, 1'b0);
    add("bwd_dec5",    I_DEC,                 23'd5, 1'b1, 1'b1, 1'b0);
    // restart and reader reload beat a same-cycle step
    add("rstrt_reg",   I_RSTRT,               23'd5, 1'b1, 1'b1, 1'b0);
    add("rstrt_inc",   I_RSTRT | I_INC,       A_END, 1'b1, 1'b1, 1'b0);
    add("arst_inc",    I_ARST | I_INC,        A_END, 1'b1, 1'b1, 1'b0);
    add("inc_dec",     I_INC | I_DEC,         A_END, 1'b1, 1'b1, 1'b0);
    // pause / play
    add("pau_reg",     I_PAU,                 A_END, 1'b1, 1'b1, 1'b0);
    add("pau_ev",      I_PAU,                 A_END, 1'b1, 1'b0, 1'b0);
    add("pau_step",    I_INC,                 A_EM1, 1'b1, 1'b0, 1'b0);
    add("pp_reg",      I_PAU | I_PLY,         A_EM1, 1'b1, 1'b0, 1'b0);
    add("pp_ev",       I_PAU | I_PLY,         A_EM1, 1'b1, 1'b0, 1'b0);
    add("pp_idle",     I_NONE,                A_EM1, 1'b1, 1'b0, 1'b0);
    add("ply_reg",     I_PLY,                 A_EM1, 1'b1, 1'b0, 1'b0);
    add("ply_ev",      I_PLY,                 A_EM1, 1'b1, 1'b1, 1'b0);
    add("ply_idle",    I_NONE,                A_EM1, 1'b1, 1'b1, 1'b0);
    // forward/backward conflict ignored
    add("fb_reg",      I_FWD | I_BWD,         A_EM1, 1'b1, 1'b1, 1'b0);
    add("fb_ev",       I_FWD | I_BWD,         A_EM1, 1'b1, 1'b1, 1'b0);
    add("fb_idle",     I_NONE,                A_EM1, 1'b1, 1'b1, 1'b0);
    // back to forward, forward wrap
    add("fwd_reg",     I_FWD,                 A_EM1, 1'b1, 1'b1, 1'b0);
    add("fwd_ev",      I_FWD,                 A_EM1, 1'b0, 1'b1, 1'b0);
    add("fwd_to_end",  I_INC,                 A_END, 1'b0, 1'b1, 1'b0);
    add("fwd_wrap",    I_INC,                 23'd0, 1'b0, 1'b1, 1'b1);
    add("fwd_wr_off",  I_NONE,                23'd0, 1'b0, 1'b1, 1'b0);
    // reset overrides pulse; command held through reset fires once after
    add("rst_pulse",   I_RST | I_INC | I_BWD, 23'd0, 1'b0, 1'b1, 1'b0);
    add("held_reg",    I_BWD,                 23'd0, 1'b0, 1'b1, 1'b0);
    add("held_ev",     I_BWD,                 23'd0, 1'b1, 1'b1, 1'b0);
    add("held_hold",   I_BWD,                 23'd0, 1'b1, 1'b1, 1'b0);
    add("rst_bwd",     I_RST,                 23'd0, 1'b0, 1'b1, 1'b0);
    add("arst_fwd",    I_ARST,                23'd0, 1'b0, 1'b1, 1'b0);

    foreach (vecs[i]) begin
      drive(vecs[i].in);
      tick();
      check(vecs[i].name, vecs[i].addr, vecs[i].dir, vecs[i].pe, vecs[i].wr);
    end

    // back-to-back reader pulses, one step per cycle
    for (int k = 1; k <= 5; k++) begin
      drive(I_INC);
      tick();
      check("b2b_inc", 23'(k), 1'b0, 1'b1, 1'b0);
    end

    // forward restart reloads start without wrap; held level fires only once
    drive(I_RSTRT);
    tick();
    check("f_rstrt_reg", 23'd5, 1'b0, 1'b1, 1'b0);
    tick();
    check("f_rstrt_ev", 23'd0, 1'b0, 1'b1, 1'b0);
    drive(I_RSTRT | I_INC);
    tick();
    check("f_rstrt_held", 23'd1, 1'b0, 1'b1, 1'b0);
    drive(I_INC);
    tick();
    check("f_rstrt_inc", 23'd2, 1'b0, 1'b1, 1'b0);
    drive(I_NONE);
    tick();
    check("f_idle", 23'd2, 1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
